// File: rtl/obi_icn_arbiter_pkg.sv
// Shared definitions for the OBI interconnect arbiter: FSM state encoding and bus-width defaults.
package obi_icn_arbiter_pkg;

    localparam int OBI_AW_DEFAULT = 32;
    localparam int OBI_DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/obi_icn_arbiter_rr_select.sv
// Round-robin selector: picks the first requester strictly after ptr_i, wrapping around.
module rr_select #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        // Walk from the farthest candidate to the nearest so the nearest eligible one is kept.
        for (int d = N; d >= 1; d--) begin
            cand = int'(ptr_i) + d;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req_i[cand]) begin
                onehot_o       = '0;
                onehot_o[cand] = 1'b1;
                idx_o          = IW'(cand);
                valid_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/obi_icn_arbiter.sv
// N-to-1 OBI arbiter with a single outstanding transaction, zero-latency IDLE pass-through
// and a response-phase timeout that fabricates an error response.
module obi_icn_arbiter
    import obi_icn_arbiter_pkg::*;
#(
    parameter int NUM_INIT       = 2,
    parameter int OBI_AW         = OBI_AW_DEFAULT,
    parameter int OBI_DW         = OBI_DW_DEFAULT,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int IW            = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_INIT-1:0]        init_en_i,
    input  logic [NUM_INIT-1:0]        init_req_i,
    input  logic [NUM_INIT*OBI_AW-1:0] init_addr_i,
    input  logic [NUM_INIT-1:0]        init_we_i,
    input  logic [NUM_INIT*OBI_DW/8-1:0] init_be_i,
    input  logic [NUM_INIT*OBI_DW-1:0] init_wdata_i,
    input  logic [NUM_INIT-1:0]        init_rready_i,
    output logic [NUM_INIT-1:0]        init_gnt_o,
    output logic [NUM_INIT-1:0]        init_rvalid_o,
    output logic [OBI_DW-1:0]          init_rdata_o,
    output logic                       init_err_o,
    output logic                       tgt_req_o,
    output logic [OBI_AW-1:0]          tgt_addr_o,
    output logic                       tgt_we_o,
    output logic [OBI_DW/8-1:0]        tgt_be_o,
    output logic [OBI_DW-1:0]          tgt_wdata_o,
    output logic                       tgt_rready_o,
    input  logic                       tgt_gnt_i,
    input  logic                       tgt_rvalid_i,
    input  logic [OBI_DW-1:0]          tgt_rdata_i,
    input  logic                       tgt_err_i,
    output logic [IW-1:0]              owner_o,
    output logic                       busy_o,
    output logic                       timeout_o,
    input  logic                       timeout_clr_i
);

    localparam int BW = OBI_DW / 8;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Handshakes: the address phase completes in a cycle where req and gnt are both high;
    // the response phase completes in a cycle where rvalid and rready are both high.
    arb_state_e          state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
    logic                to_set;

    logic [NUM_INIT-1:0] eligible;
    logic [NUM_INIT-1:0] win_onehot;
    logic [IW-1:0]       win_idx;
    logic                win_valid;
    logic [IW-1:0]       sel_idx;
    logic                addr_phase;
    logic                cnt_expired;

    assign eligible    = init_req_i & init_en_i;
    assign sel_idx     = (state_q == IDLE) ? win_idx : owner_q;
    assign addr_phase  = ((state_q == IDLE) && win_valid) || (state_q == ADDR);
    assign cnt_expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    rr_select #(
        .N  (NUM_INIT),
        .IW (IW)
    ) u_rr_select (
        .req_i    (eligible),
        .ptr_i    (rr_ptr_q),
        .onehot_o (win_onehot),
        .idx_o    (win_idx),
        .valid_o  (win_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= IW'(NUM_INIT - 1);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        to_set        = 1'b0;
        init_gnt_o    = '0;
        init_rvalid_o = '0;
        init_rdata_o  = '0;
        init_err_o    = 1'b0;
        tgt_req_o     = 1'b0;
        tgt_addr_o    = '0;
        tgt_we_o      = 1'b0;
        tgt_be_o      = '0;
        tgt_wdata_o   = '0;
        tgt_rready_o  = 1'b1;

        if (addr_phase) begin
            tgt_req_o   = 1'b1;
            tgt_addr_o  = init_addr_i[int'(sel_idx)*OBI_AW +: OBI_AW];
            tgt_we_o    = init_we_i[sel_idx];
            tgt_be_o    = init_be_i[int'(sel_idx)*BW +: BW];
            tgt_wdata_o = init_wdata_i[int'(sel_idx)*OBI_DW +: OBI_DW];
            if (state_q == IDLE) begin
                init_gnt_o = win_onehot & {NUM_INIT{tgt_gnt_i}};
            end else begin
                init_gnt_o[owner_q] = tgt_gnt_i;
            end
        end

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    owner_d = win_idx;
                    if (tgt_gnt_i) begin
                        state_d  = RESP;
                        rr_ptr_d = win_idx;
                        cnt_d    = '0;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (tgt_gnt_i) begin
                    state_d  = RESP;
                    rr_ptr_d = owner_q;
                    cnt_d    = '0;
                end
            end
            RESP: begin
                tgt_rready_o           = init_rready_i[owner_q];
                init_rvalid_o[owner_q] = tgt_rvalid_i;
                init_rdata_o           = tgt_rdata_i;
                init_err_o             = tgt_err_i;
                // A response arriving on the expiry cycle takes priority over the timeout.
                if (tgt_rvalid_i) begin
                    if (init_rready_i[owner_q]) begin
                        state_d = IDLE;
                    end
                end else if (cnt_expired) begin
                    state_d = ERR;
                    to_set  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERR: begin
                init_rvalid_o[owner_q] = 1'b1;
                init_err_o             = 1'b1;
                if (init_rready_i[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        timeout_d = to_set | (timeout_q & ~timeout_clr_i);

        if (reset) begin
            init_gnt_o    = '0;
            init_rvalid_o = '0;
            init_rdata_o  = '0;
            init_err_o    = 1'b0;
            tgt_req_o     = 1'b0;
        end
    end

    assign owner_o   = owner_q;
    assign busy_o    = (state_q != IDLE);
    assign timeout_o = timeout_q;

endmodule

// File: doc/obi_icn_arbiter.md
OBI_ICN_ARBITER -- requirements
Module: obi_icn_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_INIT, 2, number of OBI initiators
- OBI_AW, 32, address width
- OBI_DW, 32, data width
- TIMEOUT_CYCLES, 255, response-phase cycles before an error response is generated
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, the single clock
- reset, in, 1, synchronous, active-high
- init_en_i, in, NUM_INIT, per-initiator enable
- init_req_i, in, NUM_INIT, initiator req
- init_addr_i, in, NUM_INIT*OBI_AW, addr
- init_we_i, in, NUM_INIT, we
- init_be_i, in, NUM_INIT*OBI_DW/8, be
- init_wdata_i, in, NUM_INIT*OBI_DW, wdata
- init_rready_i, in, NUM_INIT, rready
- init_gnt_o, out, NUM_INIT, gnt
- init_rvalid_o, out, NUM_INIT, rvalid
- init_rdata_o, out, OBI_DW, shared rdata
- init_err_o, out, 1, shared err
- tgt_req_o, out, 1, req
- tgt_addr_o, out, OBI_AW, addr
- tgt_we_o, out, 1, we
- tgt_be_o, out, OBI_DW/8, be
- tgt_wdata_o, out, OBI_DW, wdata
- tgt_rready_o, out, 1, rready
- tgt_gnt_i, in, 1, gnt
- tgt_rvalid_i, in, 1, rvalid
- tgt_rdata_i, in, OBI_DW, rdata
- tgt_err_i, in, 1, err
- owner_o, out, clog2(NUM_INIT), current or last owner
- busy_o, out, 1, FSM not in IDLE
- timeout_o, out, 1, sticky timeout flag
- timeout_clr_i, in, 1, clears timeout_o
REQ-003 Clock and reset SHALL be the single clock clk and reset, synchronous and active-high.

Function
REQ-004 The arbiter SHALL allow one outstanding transaction; FSM states are IDLE, ADDR, RESP, ERR.
REQ-005 An initiator SHALL be eligible only when init_req_i[k] and init_en_i[k] are both high.
REQ-006 The IDLE winner SHALL be chosen combinationally by round robin, starting at the index after the last address handshake.
REQ-007 In IDLE with a winner, tgt_req_o and the winner's address-phase signals SHALL pass through in the same cycle (zero added latency).
REQ-008 In IDLE, init_gnt_o[winner] SHALL equal tgt_gnt_i.
REQ-009 IDLE SHALL go to RESP on handshake, or to ADDR with the owner registered if tgt_gnt_i is low.
REQ-010 In ADDR, the owner SHALL be locked and its request forwarded until tgt_gnt_i, then go to RESP; no timeout applies in ADDR.
REQ-011 The round-robin pointer SHALL update to the owner on the address handshake only.
REQ-012 In RESP, tgt_rready_o SHALL equal init_rready_i[owner].
REQ-013 In RESP, init_rvalid_o[owner] SHALL equal tgt_rvalid_i, and rdata/err SHALL pass through.
REQ-014 RESP SHALL go to IDLE when tgt_rvalid_i and rready are both high.
REQ-015 No new request SHALL be granted in that same cycle; the earliest next grant is the following cycle.
REQ-016 The timeout counter SHALL clear on entering RESP and increment each RESP cycle while tgt_rvalid_i is low.
REQ-017 When the counter reaches TIMEOUT_CYCLES-1 with tgt_rvalid_i low, the FSM SHALL go to ERR.
REQ-018 If tgt_rvalid_i and the timeout occur in the same cycle, the response SHALL win.
REQ-019 In ERR, init_rvalid_o[owner]=1, init_err_o=1 and init_rdata_o=0 SHALL hold until init_rready_i[owner], then go to IDLE.
REQ-020 timeout_o SHALL set on entry to ERR and clear on timeout_clr_i; a same-cycle set SHALL win over clear.
REQ-021 In IDLE, ADDR and ERR, tgt_rready_o SHALL be 1, and any stray tgt_rvalid_i SHALL be dropped without reaching an initiator.
REQ-022 Deasserting init_en_i of the owner mid-transaction SHALL NOT abort the transaction.
REQ-023 Non-owner init_gnt_o and init_rvalid_o SHALL be 0 in every state.
REQ-024 In IDLE with no winner, tgt_req_o SHALL be 0 and the target address-phase outputs SHALL be 0.

Reset
REQ-025 On reset the block SHALL set: FSM=IDLE, RR pointer=NUM_INIT-1 (initiator 0 wins first), counter=0, owner_o=0, busy_o=0, timeout_o=0.
REQ-026 During reset, all gnt, rvalid, err and tgt_req_o outputs SHALL be 0.
REQ-027 Reset asserted mid-transaction SHALL return the block to IDLE on the next edge, with no response delivered.

Structure
REQ-028 A shared package SHALL hold the FSM state enum and the OBI_AW/OBI_DW defaults.
REQ-029 The round-robin selector SHALL be one sub-module, rr_select (request vector plus pointer in, one-hot and index out).
REQ-030 The FSM, counter and muxing SHALL reside in obi_icn_arbiter.

Verification
REQ-031 Bench SHALL cover: both req high at reset release with tgt_gnt=1 -> init 0 granted cycle 0, init 1 granted after init 0's response.
REQ-032 Bench SHALL cover: tgt_gnt low 3 cycles while init 0 requests and init 1 raises req -> owner stays 0, tgt_addr stable, pointer unchanged until gnt.
REQ-033 Bench SHALL cover: TIMEOUT_CYCLES=8, target never responds -> after 8 RESP cycles, rvalid=1, err=1, rdata=0, timeout_o=1; timeout_clr_i -> 0.
REQ-034 Bench SHALL cover: rvalid in the same cycle as the counter reaching 7 -> normal response, timeout_o stays 0.
REQ-035 Bench SHALL cover: init_en_i=2'b10 with both requesting -> only init 1 granted, repeatedly.
REQ-036 Bench SHALL cover: reset in RESP -> next cycle busy_o=0, no rvalid; stray tgt_rvalid in IDLE -> dropped.
